// File: rtl/er_cmd_fetch.sv
// Earthrise command-list sequencer: issues reads to the list memory, hides its
// 2-cycle latency with a prefetch FIFO and streams commands over valid/ready.
module er_cmd_fetch #(
  parameter int unsigned WORD       = 32,
  parameter int unsigned ADDRW      = 9,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADDRW-1:0] start_addr,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [ADDRW-1:0] addr_er,
  input  logic [WORD-1:0]  dout_er,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [WORD-1:0]  cmd_data
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DepthC = FIFO_DEPTH[CW:0];

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e           state_q;
  logic [ADDRW-1:0] start_q;
  logic [ADDRW-1:0] next_q;
  logic             iss_q;
  logic             v1_q;
  logic             v2_q;
  logic [WORD-1:0]  fifo_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  logic        end_hit;
  logic        push;
  logic        pop;
  logic        room;
  logic        drained;
  logic [CW:0] occ;

  // v2_q marks the cycle in which dout_er carries the word issued two cycles earlier.
  assign end_hit = v2_q && (dout_er[WORD-1 -: 4] == 4'h0);
  assign push    = v2_q && !end_hit;
  assign pop     = cmd_valid && cmd_ready;
  // Reserve a FIFO slot for every read still in the pipeline so the FIFO never overflows.
  assign occ     = {1'b0, count_q} + {{CW{1'b0}}, iss_q} + {{CW{1'b0}}, v1_q}
                 + {{CW{1'b0}}, v2_q};
  assign room    = occ < DepthC;
  assign drained = (count_q == '0) && !iss_q && !v1_q && !v2_q;

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDrain) && drained && !abort;
  assign cmd_valid = (count_q != '0);
  assign cmd_data  = fifo_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= dout_er;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      start_q  <= '0;
      next_q   <= '0;
      addr_er  <= '0;
      iss_q    <= 1'b0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err      <= 1'b0;
    end else if (abort) begin
      state_q  <= StIdle;
      iss_q    <= 1'b0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push != pop) begin
        count_q <= push ? count_q + 1'b1 : count_q - 1'b1;
      end
      iss_q <= 1'b0;
      v1_q  <= iss_q;
      v2_q  <= v1_q;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StFetch;
            start_q <= start_addr;
            addr_er <= start_addr;
            next_q  <= start_addr + 1'b1;
            iss_q   <= 1'b1;
            err     <= 1'b0;
          end
        end
        StFetch: begin
          if (end_hit) begin
            // Reads issued past the END word are dropped by clearing their tags.
            state_q <= StDrain;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
          end else if (next_q == start_q) begin
            state_q <= StDrain;
            err     <= 1'b1;
          end else if (room) begin
            iss_q   <= 1'b1;
            addr_er <= next_q;
            next_q  <= next_q + 1'b1;
          end
        end
        StDrain: begin
          if (end_hit) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
          end else if (drained) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_er_cmd_fetch.sv
// Directed bench for er_cmd_fetch: a default-size instance plus an ADDRW=4
// instance for the full-list wrap case, each with a 2-cycle-latency memory model.
module tb_er_cmd_fetch;

  logic        clk;
  logic        rst;
  logic        start_a, abort_a, busy_a, done_a, err_a, cmd_valid_a, cmd_ready_a;
  logic [8:0]  start_addr_a, addr_er_a;
  logic [31:0] dout_er_a, cmd_data_a, pa;
  logic        start_b, abort_b, busy_b, done_b, err_b, cmd_valid_b, cmd_ready_b;
  logic [3:0]  start_addr_b, addr_er_b;
  logic [31:0] dout_er_b, cmd_data_b, pb;

  logic [31:0] mem_a [512];
  logic [31:0] mem_b [16];

  int checks = 0;
  int errors = 0;

  logic [31:0] got_q [$];
  int first_valid, n_done, done_cyc, stab_err;
  logic busy_at_done, err_c1;
  logic [8:0] addr_c1;

  er_cmd_fetch #(.WORD(32), .ADDRW(9), .FIFO_DEPTH(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .start_addr(start_addr_a), .abort(abort_a),
    .busy(busy_a), .done(done_a), .err(err_a), .addr_er(addr_er_a), .dout_er(dout_er_a),
    .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a), .cmd_data(cmd_data_a)
  );

  er_cmd_fetch #(.WORD(32), .ADDRW(4), .FIFO_DEPTH(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .start_addr(start_addr_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .err(err_b), .addr_er(addr_er_b), .dout_er(dout_er_b),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_data(cmd_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    pa        <= mem_a[addr_er_a];
    dout_er_a <= pa;
    pb        <= mem_b[addr_er_b];
    dout_er_b <= pb;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Entered at a negedge (cycle 0); start is sampled at the following posedge.
  task automatic run_list(input bit inst_b, input logic [8:0] sa, input int mode,
                          input int budget, input int extra_start);
    logic v, r, dn, prev_stall;
    logic [31:0] d, prev_d;
    got_q.delete();
    first_valid = -1; n_done = 0; done_cyc = -1; stab_err = 0;
    busy_at_done = 1'b0; err_c1 = 1'bx; addr_c1 = 'x;
    prev_stall = 1'b0; prev_d = '0;
    if (inst_b) begin start_b = 1'b1; start_addr_b = sa[3:0]; end
    else begin start_a = 1'b1; start_addr_a = sa; end
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
      if (c == extra_start) begin
        if (inst_b) begin start_b = 1'b1; start_addr_b = 4'h3; end
        else begin start_a = 1'b1; start_addr_a = 9'h010; end
      end
      v  = inst_b ? cmd_valid_b : cmd_valid_a;
      d  = inst_b ? cmd_data_b : cmd_data_a;
      dn = inst_b ? done_b : done_a;
      if (c == 1) begin
        err_c1  = inst_b ? err_b : err_a;
        addr_c1 = inst_b ? {5'd0, addr_er_b} : addr_er_a;
      end
      if (prev_stall && !(v && d == prev_d)) stab_err++;
      if (v && first_valid < 0) first_valid = c;
      if (dn) begin
        n_done++;
        done_cyc = c;
        busy_at_done = inst_b ? busy_b : busy_a;
      end
      r = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 3 == 0) : (c >= 25);
      if (inst_b) cmd_ready_b = r; else cmd_ready_a = r;
      if (v && r) got_q.push_back(d);
      prev_stall = v && !r;
      prev_d = d;
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
    end
    cmd_ready_a = 1'b0; cmd_ready_b = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem_a[i] = 32'hF000_0000 | i;
    mem_a[9'h010] = 32'h1000_0001;
    mem_a[9'h011] = 32'h2000_0002;
    mem_a[9'h012] = 32'h0000_0000;
    for (int i = 0; i < 20; i++) mem_a[9'h040 + i] = 32'h1000_0040 + i;
    mem_a[9'h054] = 32'h0000_0054;
    for (int i = 0; i < 16; i++) mem_b[i] = 32'h1000_0000 | i;

    rst = 1'b1;
    start_a = 0; abort_a = 0; cmd_ready_a = 0; start_addr_a = '0;
    start_b = 0; abort_b = 0; cmd_ready_b = 0; start_addr_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_addr", addr_er_a, 0);
    chk("rst_valid", cmd_valid_a, 0);
    chk("rst_b_valid", cmd_valid_b, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: short list, always ready
    run_list(0, 9'h010, 0, 40, -1);
    chk("t1_addr_c1", addr_c1, 9'h010);
    chk("t1_first_valid", first_valid, 4);
    chk("t1_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("t1_cmd0", got_q[0], 32'h1000_0001);
      chk("t1_cmd1", got_q[1], 32'h2000_0002);
    end
    chk("t1_ndone", n_done, 1);
    chk("t1_done_cyc", done_cyc, 6);
    chk("t1_busy_at_done", busy_at_done, 1);
    chk("t1_busy_after", busy_a, 0);
    chk("t1_err", err_a, 0);

    // 2: same list, ready one cycle in three
    run_list(0, 9'h010, 1, 40, -1);
    chk("t2_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("t2_cmd0", got_q[0], 32'h1000_0001);
      chk("t2_cmd1", got_q[1], 32'h2000_0002);
    end
    chk("t2_stable", stab_err, 0);
    chk("t2_ndone", n_done, 1);

    // Long list with the FIFO held full, plus a start pulse while busy
    run_list(0, 9'h040, 2, 120, 12);
    chk("t4f_count", got_q.size(), 20);
    for (int i = 0; i < 20 && i < got_q.size(); i++)
      chk($sformatf("t4f_cmd%0d", i), got_q[i], 32'h1000_0040 + i);
    chk("t4f_stable", stab_err, 0);
    chk("t4f_ndone", n_done, 1);
    chk("t4f_first_valid", first_valid, 4);

    // 3: ADDRW=4 wrap with no END
    run_list(1, 9'h00E, 0, 60, -1);
    chk("t3_count", got_q.size(), 16);
    for (int i = 0; i < 16 && i < got_q.size(); i++)
      chk($sformatf("t3_cmd%0d", i), got_q[i], 32'h1000_0000 | ((14 + i) % 16));
    chk("t3_ndone", n_done, 1);
    chk("t3_done_cyc", done_cyc, 20);
    chk("t3_err", err_b, 1);
    repeat (3) @(negedge clk);
    chk("t3_err_sticky", err_b, 1);
    run_list(1, 9'h00E, 0, 60, -1);
    chk("t3_err_cleared_by_start", err_c1, 0);
    chk("t3b_count", got_q.size(), 16);

    // 4: abort with FIFO at 6 entries and 2 reads in flight
    start_a = 1'b1; start_addr_a = 9'h040; cmd_ready_a = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    chk("t4_pre_valid", cmd_valid_a, 1);
    chk("t4_pre_data", cmd_data_a, 32'h1000_0040);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("t4_abort_valid", cmd_valid_a, 0);
    chk("t4_abort_busy", busy_a, 0);
    run_list(0, 9'h010, 0, 40, -1);
    chk("t4_new_first_valid", first_valid, 4);
    chk("t4_new_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("t4_new_cmd0", got_q[0], 32'h1000_0001);
      chk("t4_new_cmd1", got_q[1], 32'h2000_0002);
    end

    // 5: start+abort together while idle, then while busy
    start_a = 1'b1; abort_a = 1'b1; start_addr_a = 9'h040;
    @(negedge clk);
    start_a = 1'b0; abort_a = 1'b0;
    chk("t5_sa_idle_busy", busy_a, 0);
    repeat (4) @(negedge clk);
    chk("t5_sa_idle_valid", cmd_valid_a, 0);
    start_a = 1'b1; start_addr_a = 9'h040;
    repeat (5) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    chk("t5_busy_before", busy_a, 1);
    start_a = 1'b1; abort_a = 1'b1; start_addr_a = 9'h010;
    @(negedge clk);
    start_a = 1'b0; abort_a = 1'b0;
    chk("t5_sa_busy_busy", busy_a, 0);
    chk("t5_sa_busy_valid", cmd_valid_a, 0);
    repeat (3) @(negedge clk);
    chk("t5_sa_busy_quiet", cmd_valid_a, 0);

    // 5: reset in the middle of a list
    start_a = 1'b1; start_addr_a = 9'h040; cmd_ready_a = 1'b1;
    repeat (6) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    chk("t5_mid_valid", cmd_valid_a, 1);
    chk("t5_b_err_pre", err_b, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; cmd_ready_a = 1'b0;
    chk("t5_rst_busy", busy_a, 0);
    chk("t5_rst_done", done_a, 0);
    chk("t5_rst_err", err_a, 0);
    chk("t5_rst_addr", addr_er_a, 0);
    chk("t5_rst_valid", cmd_valid_a, 0);
    chk("t5_rst_b_err", err_b, 0);
    repeat (4) @(negedge clk);
    chk("t5_rst_quiet", cmd_valid_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
